// File: rtl/pc_unit.sv
// Program counter for the fetch stage: sequential advance, jump load, and
// edge-triggered vectored interrupt entry with EPC save/restore on return.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET     = '0,
  parameter int unsigned     NUM_IRQ   = 8,
  parameter logic [XLEN-1:0] TRAP_BASE = XLEN'('h100),
  parameter bit              VECTORED  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic [XLEN-1:0]      pc_o,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 setPc_i,
  input  logic                 advance_i,
  input  logic [NUM_IRQ-1:0]   irq_i,
  input  logic [NUM_IRQ-1:0]   irqEnable_i,
  input  logic                 gie_i,
  input  logic                 mret_i,
  output logic [NUM_IRQ-1:0]   irqAck_o,
  output logic [(NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1)-1:0] irqCause_o,
  output logic [XLEN-1:0]      epc_o,
  output logic                 inHandler_o
);

  localparam int unsigned CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {RUN, HANDLER} state_t;

  state_t              state;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  pend;
  logic [NUM_IRQ-1:0]  req;
  logic [NUM_IRQ-1:0]  take_vec;
  logic [CW-1:0]       win;
  logic                bnd;
  logic                take;
  logic [XLEN-1:0]     target;
  logic [XLEN-1:0]     nxt;
  logic [XLEN-1:0]     vec_pc;

  // Target bits [1:0] are architecturally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_i[1:0];

  assign req    = pend & irqEnable_i;
  assign bnd    = setPc_i | advance_i;
  assign target = {pc_i[XLEN-1:2], 2'b00};
  assign nxt    = setPc_i ? target : pc_o + XLEN'(4);
  assign take   = (state == RUN) && gie_i && (|req) && bnd;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win = '0;
    // Scan downward so the lowest requesting index wins.
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (req[k]) win = CW'(k);
    end
  end

  assign take_vec = take ? (NUM_IRQ'(1) << win) : '0;
  assign vec_pc   = TRAP_BASE + (VECTORED ? (XLEN'(win) << 2) : '0);

  assign inHandler_o = (state == HANDLER);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RUN;
      pc_o       <= RESET;
      epc_o      <= '0;
      irqCause_o <= '0;
      irqAck_o   <= '0;
      irq_q      <= '0;
      pend       <= '0;
    end else begin
      irq_q    <= irq_i;
      // A fresh edge on the line being taken wins over the clear.
      pend     <= (pend & ~take_vec) | (irq_i & ~irq_q);
      irqAck_o <= take_vec;
      case (state)
        RUN: begin
          if (take) begin
            epc_o      <= nxt;
            irqCause_o <= win;
            pc_o       <= vec_pc;
            state      <= HANDLER;
          end else if (bnd) begin
            pc_o <= nxt;
          end
        end
        HANDLER: begin
          if (mret_i) begin
            pc_o  <= epc_o;
            state <= RUN;
          end else if (bnd) begin
            pc_o <= nxt;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: a vectored instance plus a
// non-vectored instance used for the global-enable scenario.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        set_pc, advance, gie, mret;
  logic [7:0]  irq, irq_en;
  logic [31:0] pc, epc;
  logic [7:0]  ack;
  logic [2:0]  cause;
  logic        in_h;

  logic        v_adv, v_gie;
  logic [7:0]  v_irq, v_en;
  logic [31:0] v_pc, v_epc;
  logic [7:0]  v_ack;
  logic [2:0]  v_cause;
  logic        v_inh;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_o(pc), .pc_i(pc_in), .setPc_i(set_pc),
    .advance_i(advance), .irq_i(irq), .irqEnable_i(irq_en), .gie_i(gie),
    .mret_i(mret), .irqAck_o(ack), .irqCause_o(cause), .epc_o(epc),
    .inHandler_o(in_h)
  );

  pc_unit #(.VECTORED(1'b0)) dut_nv (
    .clk_i(clk), .rst_ni(rst_n), .pc_o(v_pc), .pc_i(32'h0), .setPc_i(1'b0),
    .advance_i(v_adv), .irq_i(v_irq), .irqEnable_i(v_en), .gie_i(v_gie),
    .mret_i(1'b0), .irqAck_o(v_ack), .irqCause_o(v_cause), .epc_o(v_epc),
    .inHandler_o(v_inh)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_in = '0; set_pc = 0; advance = 0; gie = 0; mret = 0;
    irq = '0; irq_en = '0;
    v_adv = 0; v_gie = 0; v_irq = '0; v_en = '0;

    // Reset state
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cause", 32'(cause), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_inh", 32'(in_h), 32'h0);
    #9 rst_n = 1'b1;

    // Sequential advance
    advance = 1;
    tick(); check("adv_4", pc, 32'h4);
    tick(); check("adv_8", pc, 32'h8);
    tick(); check("adv_c", pc, 32'hC);

    // Asynchronous reset mid-sequence
    #2 rst_n = 1'b0;
    #1 check("async_rst_pc", pc, 32'h0);
    #1 rst_n = 1'b1;
    tick(); check("adv_after_rst", pc, 32'h4);

    // Jump load, low bits ignored, wrap-around
    advance = 0; set_pc = 1; pc_in = 32'h20;
    tick(); check("set_20", pc, 32'h20);
    pc_in = 32'h1003;
    tick(); check("set_1003", pc, 32'h1000);
    pc_in = 32'hFFFF_FFFC;
    tick(); check("set_top", pc, 32'hFFFF_FFFC);
    set_pc = 0; advance = 1;
    tick(); check("wrap", pc, 32'h0);

    // Single interrupt on line 3
    gie = 1; irq_en = 8'hFF; advance = 0; set_pc = 1; pc_in = 32'h40;
    tick(); check("pc_40", pc, 32'h40);
    set_pc = 0; irq = 8'h08;
    tick(); check("no_bnd_hold", pc, 32'h40);
    check("no_bnd_inh", 32'(in_h), 32'h0);
    irq = 8'h00; advance = 1;
    tick();
    check("irq3_pc", pc, 32'h10C);
    check("irq3_epc", epc, 32'h44);
    check("irq3_cause", 32'(cause), 32'h3);
    check("irq3_ack", 32'(ack), 32'h08);
    check("irq3_inh", 32'(in_h), 32'h1);
    advance = 0;
    tick();
    check("irq3_ack_off", 32'(ack), 32'h0);
    check("irq3_hold", pc, 32'h10C);
    mret = 1;
    tick();
    check("mret_pc", pc, 32'h44);
    check("mret_inh", 32'(in_h), 32'h0);
    mret = 0;

    // Simultaneous lines 5 and 2
    irq = 8'h24;
    tick(); check("two_hold", pc, 32'h44);
    irq = 8'h00; set_pc = 1; pc_in = 32'h80;
    tick();
    check("two_l2_pc", pc, 32'h108);
    check("two_l2_epc", epc, 32'h80);
    check("two_l2_cause", 32'(cause), 32'h2);
    check("two_l2_ack", 32'(ack), 32'h04);
    set_pc = 0; mret = 1;
    tick(); check("two_mret_pc", pc, 32'h80);
    mret = 0; advance = 1;
    tick();
    check("two_l5_pc", pc, 32'h114);
    check("two_l5_epc", epc, 32'h84);
    check("two_l5_cause", 32'(cause), 32'h5);
    check("two_l5_ack", 32'(ack), 32'h20);

    // Edge while in handler: no nesting, stays pending
    irq = 8'h02;
    tick();
    check("nest_pc", pc, 32'h118);
    check("nest_inh", 32'(in_h), 32'h1);
    check("nest_cause", 32'(cause), 32'h5);
    irq = 8'h00; advance = 0; mret = 1;
    tick(); check("nest_mret_pc", pc, 32'h84);
    mret = 0; advance = 1;
    tick();
    check("l1_pc", pc, 32'h104);
    check("l1_epc", epc, 32'h88);
    check("l1_cause", 32'(cause), 32'h1);
    advance = 0; mret = 1;
    tick(); check("l1_mret_pc", pc, 32'h88);

    // mret ignored in RUN
    advance = 1;
    tick();
    check("run_mret_pc", pc, 32'h8C);
    check("run_mret_inh", 32'(in_h), 32'h0);
    mret = 0; advance = 0;

    // Non-vectored instance, global enable gating
    v_en = 8'hFF; v_irq = 8'h10;
    tick(); check("nv_hold", v_pc, 32'h0);
    v_irq = 8'h00; v_adv = 1;
    tick();
    check("nv_gie0_pc", v_pc, 32'h4);
    check("nv_gie0_inh", 32'(v_inh), 32'h0);
    v_gie = 1;
    tick();
    check("nv_pc", v_pc, 32'h100);
    check("nv_cause", 32'(v_cause), 32'h4);
    check("nv_epc", v_epc, 32'h8);
    check("nv_ack", 32'(v_ack), 32'h10);
    v_adv = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
